// File: rtl/iob_ram_responder.sv
// iob_ram_responder: IOb responder backed by a byte-strobed word RAM, answering after a fixed latency.
module iob_ram_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int LATENCY = 1,
  localparam int REQ_W = 1 + ADDR_W + DATA_W + DATA_W / 8,
  localparam int RESP_W = DATA_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REQ_W-1:0]  req,
  output logic [RESP_W-1:0] resp
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] mem [2**MEM_ADDR_W];
  logic valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [MEM_ADDR_W-1:0] idx;
  logic accept, ready;
  logic unused_addr;
  assign {valid, addr, wdata, wstrb} = req;
  assign idx = addr[MEM_ADDR_W+1:2];
  assign unused_addr = ^addr;
  assign accept = state_q == IDLE && valid;
  assign ready = state_q == RESP;
  assign resp = {ready ? rdata_q : '0, ready};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    if (accept) begin
      state_d = LATENCY > 1 ? WAIT : RESP;
      cnt_d = 4'(LATENCY - 1);
      rdata_d = |wstrb ? '0 : mem[idx];
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - 4'd1;
      state_d = cnt_q == 4'd1 ? RESP : WAIT;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
    end
  // RAM is deliberately outside the reset domain so contents survive rst; the rst gate keeps a held request from writing while in reset.
  always_ff @(posedge clk)
    if (rst && accept)
      for (int b = 0; b < DATA_W / 8; b++)
        if (wstrb[b]) mem[idx][8*b+:8] <= wdata[8*b+:8];
endmodule

// File: tb/tb_iob_ram_responder.sv
// tb_iob_ram_responder: randomized and directed checks of three responders (LATENCY 1, 3, 4) against a byte-level memory model.
module tb_iob_ram_responder;
  localparam int REQ_W = 69;
  localparam int RESP_W = 33;
  logic clk = 0;
  logic rst = 0;
  logic [REQ_W-1:0] req [3];
  logic [RESP_W-1:0] resp [3];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [31:0] mm [3][1024];
  logic [3:0] kn [3][1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iob_ram_responder #(.LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .req(req[0]), .resp(resp[0]));
  iob_ram_responder #(.LATENCY(3)) u_l3 (.clk(clk), .rst(rst), .req(req[1]), .resp(resp[1]));
  iob_ram_responder #(.LATENCY(4)) u_l4 (.clk(clk), .rst(rst), .req(req[2]), .resp(resp[2]));

  function automatic int lat_of(int d);
    return d == 0 ? 1 : d == 1 ? 3 : 4;
  endfunction

  function automatic logic [31:0] kmask(int d, int i);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (kn[d][i][b]) m[8*b+:8] = 8'hFF;
    return m;
  endfunction

  task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    int i;
    i = int'(a[11:2]);
    for (int b = 0; b < 4; b++)
      if (ws[b]) begin
        mm[d][i][8*b+:8] = wd[8*b+:8];
        kn[d][i][b] = 1'b1;
      end
  endtask

  // Called at a negedge; returns response data, accept-to-ready latency (-1 on timeout) and ready one cycle later.
  task automatic xact(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      output logic [31:0] rd, output int lat, output logic after);
    int t0;
    t0 = cyc;
    lat = -1;
    rd = '0;
    after = 1'b0;
    req[d] = {1'b1, a, wd, ws};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp[d][0]) begin
        lat = cyc - t0;
        rd = resp[d][32:1];
        break;
      end
    end
    req[d] = '0;
    if (ws != 0) model_write(d, a, wd, ws);
    @(negedge clk);
    after = resp[d][0];
  endtask

  task automatic test_reset;
    int seen;
    #2;
    n_chk++;
    if (resp[0] !== '0 || resp[1] !== '0 || resp[2] !== '0) begin
      n_fail++;
      $display("FAIL reset_resp: got %h %h %h want 0", resp[0], resp[1], resp[2]);
    end
    @(negedge clk);
    rst = 1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp[0][0] || resp[1][0] || resp[2][0]) seen++;
    end
    n_chk++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL idle_no_ready: got %0d ready cycles want 0", seen);
    end
  endtask

  task automatic test_write_read;
    logic [31:0] rd;
    int lat;
    logic after;
    xact(0, 32'h10, 32'h1234_5678, 4'hF, rd, lat, after);
    n_chk++;
    if (lat !== 1 || rd !== 32'h0 || after !== 1'b0) begin
      n_fail++;
      $display("FAIL full_write: got lat=%0d rdata=%h after=%b want lat=1 rdata=0 after=0", lat, rd, after);
    end
    xact(0, 32'h10, 32'h0, 4'h0, rd, lat, after);
    n_chk++;
    if (lat !== 1 || rd !== 32'h1234_5678 || after !== 1'b0) begin
      n_fail++;
      $display("FAIL full_read: got lat=%0d rdata=%h after=%b want lat=1 rdata=12345678 after=0", lat, rd, after);
    end
  endtask

  task automatic test_strobes;
    logic [31:0] rd;
    int lat;
    logic after;
    xact(0, 32'h10, 32'hAABB_CCDD, 4'h6, rd, lat, after);
    xact(0, 32'h10, 32'h0, 4'h0, rd, lat, after);
    n_chk++;
    if (rd !== 32'h12BB_CC78) begin
      n_fail++;
      $display("FAIL byte_strobe: got %h want 12bbcc78", rd);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] rd;
    int lat;
    logic after;
    int hit;
    hit = 0;
    req[0] = {1'b1, 32'h10, 32'h0, 4'h0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp[0][0]) begin
        hit = 1;
        break;
      end
    end
    n_chk++;
    if (hit !== 1 || resp[0] !== {32'h12BB_CC78, 1'b1}) begin
      n_fail++;
      $display("FAIL pre_reset_resp: got %h want %h", resp[0], {32'h12BB_CC78, 1'b1});
    end
    #2 rst = 0;
    #1;
    n_chk++;
    if (resp[0] !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %h want 0", resp[0]);
    end
    req[0] = {1'b1, 32'h10, 32'h0, 4'h0};
    @(negedge clk);
    rst = 1;
    xact(0, 32'h10, 32'h0, 4'h0, rd, lat, after);
    n_chk++;
    if (lat !== 1 || rd !== 32'h12BB_CC78) begin
      n_fail++;
      $display("FAIL release_with_valid: got lat=%0d rdata=%h want lat=1 rdata=12bbcc78", lat, rd);
    end
  endtask

  task automatic test_alias;
    logic [31:0] rd;
    int lat;
    logic after;
    xact(0, 32'h4, 32'hCAFE_F00D, 4'hF, rd, lat, after);
    xact(0, 32'h1004, 32'h0, 4'h0, rd, lat, after);
    n_chk++;
    if (rd !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL alias: got %h want cafef00d", rd);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd, exp;
    int lat, t0, nr, extra;
    logic after;
    logic [31:0] wd [4];
    int rt [4];
    for (int k = 0; k < 4; k++) begin
      wd[k] = $urandom;
      xact(1, 32'h40 + 32'(4 * k), wd[k], 4'hF, rd, lat, after);
    end
    nr = 0;
    t0 = cyc;
    req[1] = {1'b1, 32'h40, 32'h0, 4'h0};
    for (int i = 0; i < 60 && nr < 4; i++) begin
      @(negedge clk);
      if (resp[1][0]) begin
        rt[nr] = cyc;
        exp = wd[nr];
        n_chk++;
        if (resp[1][32:1] !== exp) begin
          n_fail++;
          $display("FAIL b2b_data%0d: got %h want %h", nr, resp[1][32:1], exp);
        end
        nr++;
        req[1] = nr < 4 ? {1'b1, 32'h40 + 32'(4 * nr), 32'h0, 4'h0} : '0;
      end
    end
    req[1] = '0;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp[1][0]) extra++;
    end
    n_chk++;
    if (nr !== 4 || extra !== 0) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d responses plus %0d extra want 4 plus 0", nr, extra);
    end
    if (nr == 4) begin
      n_chk++;
      if (rt[0] - t0 !== 3) begin
        n_fail++;
        $display("FAIL b2b_first_lat: got %0d want 3", rt[0] - t0);
      end
      for (int k = 1; k < 4; k++) begin
        n_chk++;
        if (rt[k] - rt[k-1] !== 4) begin
          n_fail++;
          $display("FAIL b2b_spacing%0d: got %0d want 4", k, rt[k] - rt[k-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    int lat, seen;
    logic after;
    req[2] = {1'b1, 32'h20, 32'h55, 4'h1};
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    req[2] = '0;
    model_write(2, 32'h20, 32'h55, 4'h1);
    @(negedge clk);
    rst = 1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp[2][0]) seen++;
    end
    n_chk++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL abort_no_ready: got %0d ready cycles want 0", seen);
    end
    xact(2, 32'h20, 32'h0, 4'h0, rd, lat, after);
    n_chk++;
    if (lat !== 4 || rd[7:0] !== 8'h55) begin
      n_fail++;
      $display("FAIL write_survives_reset: got lat=%0d byte=%h want lat=4 byte=55", lat, rd[7:0]);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, wd, rd, exp, m;
    logic [3:0] ws;
    int d, lat, i;
    logic after;
    for (int n = 0; n < 40; n++) begin
      d = $urandom_range(0, 1);
      a = ($urandom & 32'hFFFF_F000) | (32'h200 + 32'(4 * $urandom_range(0, 15))) | 32'($urandom_range(0, 3));
      ws = $urandom_range(0, 2) == 0 ? 4'h0 : 4'($urandom_range(1, 15));
      wd = $urandom;
      i = int'(a[11:2]);
      exp = ws != 0 ? 32'h0 : mm[d][i];
      m = ws != 0 ? 32'hFFFF_FFFF : kmask(d, i);
      xact(d, a, wd, ws, rd, lat, after);
      n_chk++;
      if ((rd & m) !== (exp & m) || lat !== lat_of(d) || after !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d: got rdata=%h lat=%0d after=%b want rdata=%h (mask %h) lat=%0d after=0",
                 n, rd, lat, after, exp, m, lat_of(d));
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      req[d] = '0;
      for (int i = 0; i < 1024; i++) kn[d][i] = '0;
    end
    test_reset;
    test_write_read;
    test_strobes;
    test_async_reset;
    test_alias;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
